// File: rtl/lr35902_dbg_uart_rx_pkg.sv
// Shared definitions for the debug UART receive path: default timing, RX state encoding and the
// majority-vote helper.
package lr35902_dbg_uart_rx_pkg;

  localparam int unsigned BAUD_DIV_DEF   = 12;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/lr35902_dbg_fifo.sv
// Small synchronous FIFO with a registered head output. A push is accepted while full only if a pop
// happens in the same cycle; when the FIFO is empty the head output keeps its last value.
module lr35902_dbg_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [$clog2(DEPTH):0] count_next_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] data_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CW'(DEPTH));
  assign do_pop   = pop_i && !empty_o;
  assign do_push  = push_i && (!full_o || do_pop);
  assign count_d  = count_q + CW'(do_push) - CW'(do_pop);
  assign rd_ptr_d = rd_ptr_q + AW'(do_pop);

  assign rdata_o      = data_q;
  assign count_next_o = count_d;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // New head is the incoming byte only when nothing older survives this cycle.
      if (count_d != '0) begin
        if ((count_q - CW'(do_pop)) == '0) data_q <= wdata_i;
        else                               data_q <= mem_q[rd_ptr_d];
      end
    end
  end

endmodule

// File: rtl/lr35902_dbg_uart_rx.sv
// Debug UART receive front-end: rx synchroniser, 8N1 deframer with 3-sample majority voting,
// byte FIFO with valid/ready handoff, framing/overrun pulses and cts flow control.
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a low on rx_s
//   RX_START | start bit; a high majority at mid-bit is a glitch
//   RX_DATA  | eight data bits, LSB first
//   RX_STOP  | stop bit; leaves at mid-bit so back-to-back frames work
//   RX_BREAK | bad stop bit seen, waiting for the line to return high
module lr35902_dbg_uart_rx
  import lr35902_dbg_uart_rx_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = BAUD_DIV_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       uart_clk_i,
  input  logic       reset_n_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       cts_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam int unsigned H     = BAUD_DIV / 2;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       rst_sync_q;
  logic             rst_n;
  logic             rx_meta_q, rx_s_q;
  logic             s0_q, s1_q;
  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shreg_q;
  logic             frame_err_q, overrun_q, cts_q;

  logic             maj, at_h1, at_end, push_w, pop_w;
  logic             fifo_empty, fifo_full;
  logic [CW-1:0]    count_next;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge uart_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign maj    = maj3(s0_q, s1_q, rx_s_q);
  assign at_h1  = (cnt_q == CNT_W'(H + 1));
  assign at_end = (cnt_q == CNT_W'(BAUD_DIV - 1));
  assign push_w = (state_q == RX_STOP) && at_h1 && maj;
  assign pop_w  = valid_o && ready_i;

  always_ff @(posedge uart_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      cts_q       <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_s_q      <= rx_meta_q;
      frame_err_q <= 1'b0;
      overrun_q   <= push_w && fifo_full && !pop_w;
      cts_q       <= (count_next >= CW'(FIFO_DEPTH - 1));
      if (cnt_q == CNT_W'(H - 1)) s0_q <= rx_s_q;
      if (cnt_q == CNT_W'(H))     s1_q <= rx_s_q;
      case (state_q)
        RX_IDLE: begin
          if (!rx_s_q) begin
            state_q <= RX_START;
            cnt_q   <= CNT_W'(1);
          end
        end
        RX_START: begin
          if (at_h1 && maj) begin
            state_q <= RX_IDLE;
          end else if (at_end) begin
            state_q <= RX_DATA;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (at_h1) shreg_q <= {maj, shreg_q[7:1]};
          if (at_end) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) state_q <= RX_STOP;
            else               idx_q   <= idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (at_h1) begin
            if (maj) begin
              state_q <= RX_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= RX_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_BREAK: begin
          if (rx_s_q) state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  lr35902_dbg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i        (uart_clk_i),
    .rst_n_i      (rst_n),
    .push_i       (push_w),
    .wdata_i      (shreg_q),
    .pop_i        (pop_w),
    .rdata_o      (data_o),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .count_next_o (count_next)
  );

  assign valid_o     = !fifo_empty;
  assign cts_o       = cts_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_lr35902_dbg_uart_rx.sv
// Scoreboard bench for the debug UART receiver: frames are driven on rx, the expected byte stream is
// queued by a frame-level model and a separate monitor checks every valid&&ready handoff.
module tb_lr35902_dbg_uart_rx;

  localparam int DEPTH = 4;
  localparam int BIT   = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, cts, frame_err, overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  lr35902_dbg_uart_rx #(.BAUD_DIV(BIT), .FIFO_DEPTH(DEPTH)) dut (
    .uart_clk_i  (clk),
    .reset_n_i   (rst_n),
    .rx_i        (rx),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .cts_o       (cts),
    .frame_err_o (frame_err),
    .overrun_o   (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every handoff and counts flag pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pop: got 0x%0h, expected no valid at %0t", data, $time);
        end else begin
          check("pop_data", {24'h0, data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a good frame is kept if there is room, or if a pop frees a slot in the push cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int gap,
                            input logic rdy_at_push);
    rx = 1'b0;
    repeat (BIT) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) tick();
    end
    rx = stop;
    repeat (9) tick();
    if (rdy_at_push) ready = 1'b1;
    if (stop) begin
      if (exp_q.size() < DEPTH || ready) exp_q.push_back(b);
      else exp_ov++;
    end else begin
      exp_fe++;
    end
    repeat (BIT - 9) tick();
    rx = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic checkpoint(input string tag);
    check({tag, "_frame_err"}, fe_cnt, exp_fe);
    check({tag, "_overrun"}, ov_cnt, exp_ov);
    check({tag, "_cts"}, {31'h0, cts}, {31'h0, exp_q.size() >= DEPTH - 1});
    check({tag, "_valid"}, {31'h0, valid}, {31'h0, exp_q.size() > 0});
    if (exp_q.size() > 0) check({tag, "_head"}, {24'h0, data}, {24'h0, exp_q[0]});
  endtask

  task automatic drain(input string tag);
    int budget;
    ready  = 1'b1;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    tick();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_data", {24'h0, data}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_cts", {31'h0, cts}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    rst_n = 1'b1;
    repeat (4) tick();

    ready = 1'b1;
    send_frame(8'hA5, 1'b1, 4, 1'b0);
    checkpoint("a5");

    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (16) tick();
    checkpoint("glitch");

    send_frame(8'h3C, 1'b0, 12, 1'b0);
    send_frame(8'h81, 1'b1, 4, 1'b0);
    checkpoint("ferr");

    ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 0, 1'b0);
      checkpoint("fill");
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pop_cts", {31'h0, cts}, {31'h0, exp_q.size() >= DEPTH - 1});
    end
    drain("ovr");

    ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 0, 1'b0);
    checkpoint("full");
    send_frame(8'h05, 1'b1, 0, 1'b1);
    checkpoint("pushpop");
    drain("pushpop");

    ready = 1'b0;
    send_frame(8'h10, 1'b1, 0, 1'b0);
    send_frame(8'h20, 1'b1, 0, 1'b0);
    send_frame(8'h30, 1'b1, 0, 1'b0);
    rx = 1'b0;
    repeat (BIT) tick();
    for (int i = 0; i < 3; i++) begin
      rx = ((8'h77 >> i) & 8'h1) != 0;
      repeat (BIT) tick();
    end
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'h0, valid}, 32'h0);
    check("midrst_cts", {31'h0, cts}, 32'h0);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    rx = 1'b1;
    repeat (BIT * 6) tick();
    ready = 1'b1;
    send_frame(8'h42, 1'b1, 4, 1'b0);
    checkpoint("postrst");
    drain("postrst");

    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      logic       stop;
      int         gap;
      b     = 8'($urandom);
      stop  = ($urandom_range(0, 5) != 0);
      gap   = $urandom_range(0, 3) + (stop ? 0 : 3);
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        rx = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
        rx = 1'b1;
        repeat (10) tick();
      end
      send_frame(b, stop, gap, 1'b0);
      checkpoint("rand");
    end
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
